// File: rtl/div_pkg.sv
// Shared constants and types for the divide chain and its multiply-back checker.
//   QW_DEF  : default quotient / remainder width
//   MW_DEF  : default divisor width (also the multiplier iteration count)
//   state_e : two-state sequencer encoding for iterative units
//   pw_of   : product width for a QW x MW multiply with QW-bit addend
package div_pkg;

  localparam int unsigned QW_DEF = 72;
  localparam int unsigned MW_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned pw_of(input int unsigned qw, input int unsigned mw);
    return qw + mw;
  endfunction

endpackage

// File: rtl/mul_recon_block.sv
// Sequential shift-and-add multiplier reconstructing P = Q*M + R from a
// quotient, divisor and remainder. One job in flight, fixed MW-cycle latency.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   pushin       : operand valid, taken only while busy is low
//   Q_in, R_in   : multiplicand and addend (QW bits, unsigned)
//   M_in         : multiplier (MW bits, unsigned)
//   busy         : a job is running; pushin is dropped and flagged in err
//   pushout      : one-cycle result-valid pulse
//   P_out, M_out : product and the job's multiplier, held until next result
//   ovf          : result needs more than QW bits, held with P_out
//   err          : sticky, pushin seen while busy; cleared only by rst
module mul_recon_block
  import div_pkg::*;
#(
  parameter  int unsigned QW = QW_DEF,
  parameter  int unsigned MW = MW_DEF,
  localparam int unsigned PW = pw_of(QW, MW),
  localparam int unsigned CW = $clog2(MW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushin,
  input  logic [QW-1:0] Q_in,
  input  logic [QW-1:0] R_in,
  input  logic [MW-1:0] M_in,
  output logic          busy,
  output logic          pushout,
  output logic [PW-1:0] P_out,
  output logic [MW-1:0] M_out,
  output logic          ovf,
  output logic          err
);

  state_e        state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] mplier_q, mplier_d;
  logic [MW-1:0] m_hold_q, m_hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_out_q, p_out_d;
  logic [MW-1:0] m_out_q, m_out_d;
  logic          pushout_q, pushout_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [PW-1:0] acc_sum;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    m_hold_d  = m_hold_q;
    cnt_d     = cnt_q;
    p_out_d   = p_out_q;
    m_out_d   = m_out_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    pushout_d = 1'b0;

    // Accumulator after this iteration's conditional add; also the final
    // product on the last RUN edge.
    acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

    unique case (state_q)
      IDLE: begin
        if (pushin) begin
          acc_d    = {{MW{1'b0}}, R_in};
          mcand_d  = {{MW{1'b0}}, Q_in};
          mplier_d = M_in;
          m_hold_d = M_in;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (pushin) begin
          err_d = 1'b1;
        end
        if (cnt_q == CW'(MW - 1)) begin
          p_out_d   = acc_sum;
          m_out_d   = m_hold_q;
          ovf_d     = |acc_sum[PW-1:QW];
          pushout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      m_hold_q  <= '0;
      cnt_q     <= '0;
      p_out_q   <= '0;
      m_out_q   <= '0;
      pushout_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      m_hold_q  <= m_hold_d;
      cnt_q     <= cnt_d;
      p_out_q   <= p_out_d;
      m_out_q   <= m_out_d;
      pushout_q <= pushout_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign pushout = pushout_q;
  assign P_out   = p_out_q;
  assign M_out   = m_out_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mul_recon_block.sv
module tb_mul_recon_block;

  localparam int unsigned QW = 72;
  localparam int unsigned MW = 10;
  localparam int unsigned PW = 82;
  localparam logic [QW-1:0] ONES = {QW{1'b1}};

  typedef struct {
    logic [QW-1:0] q;
    logic [MW-1:0] m;
    logic [QW-1:0] r;
    logic [PW-1:0] p;
    logic          ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pushin;
  logic [QW-1:0] Q_in;
  logic [QW-1:0] R_in;
  logic [MW-1:0] M_in;
  logic          busy;
  logic          pushout;
  logic [PW-1:0] P_out;
  logic [MW-1:0] M_out;
  logic          ovf;
  logic          err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mul_recon_block #(.QW(QW), .MW(MW)) dut (
    .clk(clk), .rst(rst), .pushin(pushin),
    .Q_in(Q_in), .R_in(R_in), .M_in(M_in),
    .busy(busy), .pushout(pushout), .P_out(P_out),
    .M_out(M_out), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch a job and stop in its pushout cycle, checking the busy window.
  task automatic launch_and_wait(input vec_t v, input string tag);
    int unsigned bad;
    bad    = 0;
    Q_in   = v.q;
    R_in   = v.r;
    M_in   = v.m;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int i = 0; i < int'(MW); i++) begin
      if (busy !== 1'b1 || pushout !== 1'b0) bad++;
      step();
    end
    check({tag, "_busy_window"}, PW'(bad), '0);
    check({tag, "_pushout"}, PW'(pushout), PW'(1));
    check({tag, "_busy_low"}, PW'(busy), '0);
    check({tag, "_P"}, P_out, v.p);
    check({tag, "_M"}, PW'(M_out), PW'(v.m));
    check({tag, "_ovf"}, PW'(ovf), PW'(v.ovf));
  endtask

  task automatic run_job(input vec_t v, input string tag);
    launch_and_wait(v, tag);
    step();
    check({tag, "_pulse_end"}, PW'(pushout), '0);
    check({tag, "_P_held"}, P_out, v.p);
  endtask

  vec_t vecs [10];

  initial begin
    int unsigned n;
    int unsigned seen;
    vec_t v;

    vecs[0] = '{q: 72'd7,            m: 10'd3,    r: 72'd1, p: 82'd22,                     ovf: 1'b0};
    vecs[1] = '{q: 72'hFFFF,         m: 10'd0,    r: 72'd5, p: 82'd5,                      ovf: 1'b0};
    vecs[2] = '{q: ONES,             m: 10'd1023, r: ONES,  p: {ONES, 10'd0},              ovf: 1'b1};
    vecs[3] = '{q: 72'd100,          m: 10'd9,    r: 72'd4, p: 82'd904,                    ovf: 1'b0};
    vecs[4] = '{q: 72'd2,            m: 10'd5,    r: 72'd0, p: 82'd10,                     ovf: 1'b0};
    vecs[5] = '{q: ONES,             m: 10'd1,    r: 72'd0, p: {10'd0, ONES},              ovf: 1'b0};
    vecs[6] = '{q: ONES,             m: 10'd1,    r: 72'd1, p: {10'd1, 72'd0},             ovf: 1'b1};
    vecs[7] = '{q: 72'd0,            m: 10'd1023, r: ONES,  p: {10'd0, ONES},              ovf: 1'b0};
    vecs[8] = '{q: 72'd1,            m: 10'd1023, r: 72'd0, p: 82'd1023,                   ovf: 1'b0};
    vecs[9] = '{q: 72'h1_2345_6789,  m: 10'd512,  r: 72'd3, p: 82'h246_8ACF_1203,          ovf: 1'b0};

    rst    = 1'b1;
    pushin = 1'b0;
    Q_in   = '0;
    R_in   = '0;
    M_in   = '0;
    #1;
    check("reset_busy", PW'(busy), '0);
    check("reset_pushout", PW'(pushout), '0);
    check("reset_P", P_out, '0);
    check("reset_M", PW'(M_out), '0);
    check("reset_ovf", PW'(ovf), '0);
    check("reset_err", PW'(err), '0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: a new job taken in the pushout cycle of the previous one.
    launch_and_wait(vecs[0], "b2b_first");
    Q_in   = 72'd2;
    M_in   = 10'd5;
    R_in   = 72'd0;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    check("b2b_accepted", PW'(busy), PW'(1));
    n = 0;
    seen = 0;
    for (int i = 1; i <= 3 * int'(MW); i++) begin
      step();
      if (pushout === 1'b1) begin
        n = i;
        seen = 1;
        break;
      end
    end
    check("b2b_latency", PW'(n), PW'(MW));
    check("b2b_P", P_out, 82'd10);
    check("b2b_M", PW'(M_out), PW'(5));
    check("b2b_err", PW'(err), '0);
    step();

    // Push while busy: dropped, err sticks, in-flight job unaffected.
    Q_in   = 72'd100;
    M_in   = 10'd9;
    R_in   = 72'd4;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    step();
    step();
    Q_in   = 72'd5;
    M_in   = 10'd5;
    R_in   = 72'd5;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    check("busy_push_err", PW'(err), PW'(1));
    n = 0;
    for (int i = 4; i <= 3 * int'(MW); i++) begin
      if (pushout === 1'b1) begin
        n = i - 1;
        break;
      end
      step();
    end
    check("busy_push_latency", PW'(n), PW'(MW));
    check("busy_push_P", P_out, 82'd904);
    check("busy_push_M", PW'(M_out), PW'(9));
    seen = 0;
    for (int i = 0; i < 2 * int'(MW); i++) begin
      step();
      if (pushout === 1'b1 || busy === 1'b1) seen++;
    end
    check("dropped_job_idle", PW'(seen), '0);
    check("err_sticky", PW'(err), PW'(1));

    // Reset in the middle of a run.
    Q_in   = 72'd7;
    M_in   = 10'd3;
    R_in   = 72'd1;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", PW'(busy), '0);
    check("midrst_pushout", PW'(pushout), '0);
    check("midrst_P", P_out, '0);
    check("midrst_M", PW'(M_out), '0);
    check("midrst_ovf", PW'(ovf), '0);
    check("midrst_err", PW'(err), '0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * int'(MW); i++) begin
      step();
      if (pushout === 1'b1) seen++;
    end
    check("midrst_no_pushout", PW'(seen), '0);
    check("midrst_P_after", P_out, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_recon_block.md
Name: mul_recon_block

Overview:
- Sequential shift-and-add multiplier that runs the divide pipeline in the inverse direction: reconstructs P = Q*M + R from a quotient, divisor and remainder.
- Placed beside the restoring-divide stage chain to self-check search-engine division results, and reused wherever a narrow-multiplier product is needed.
- One operand set in flight at a time; fixed latency of MW cycles; push-style handshake with a busy back-pressure flag.

Parameters:
- QW, 72, width of multiplicand Q and addend R.
- MW, 10, width of multiplier M; also the number of iterations.
- PW, QW+MW (derived, localparam), product width.
- CW, clog2(MW+1) (derived, localparam), iteration counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pushin  in  1  operand valid; accepted only when busy=0.
- Q_in  in  QW  multiplicand (quotient).
- R_in  in  QW  addend (remainder), zero-extended.
- M_in  in  MW  multiplier (divisor), unsigned.
- busy  out  1  high while a job runs; pushin is ignored while high.
- pushout  out  1  one-cycle result-valid pulse.
- P_out  out  PW  Q*M + R, held until the next result.
- M_out  out  MW  M of the completed job, held with P_out.
- ovf  out  1  P_out[PW-1:QW] != 0, i.e. the result does not fit QW bits; held with P_out.
- err  out  1  sticky: pushin arrived while busy. Cleared only by rst.

Behaviour:
- Reset (async): state=IDLE; acc, mcand, mplier, cnt, P_out, M_out = 0; pushout=0, ovf=0, err=0; busy=0.
- All arithmetic is unsigned. acc is PW bits. mcand is PW bits, loaded as Q_in zero-extended. No truncation occurs internally.
- States: IDLE, RUN. busy = (state==RUN), decoded from the state register.
- IDLE:
  - On an edge with pushin=1: acc<=R_in, mcand<=Q_in, mplier<=M_in, m_hold<=M_in, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN, each edge:
  - if mplier[0], acc<=acc+mcand.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
- On the RUN edge where cnt==MW-1 (the MW-th RUN edge):
  - P_out<=final acc, including this iteration's add.
  - M_out<=m_hold; ovf computed from the final acc; pushout<=1; state<=IDLE.
- pushout is 1 for exactly one cycle, then returns to 0.
- Latency: operand accepted on edge k, so pushout is high in the cycle after edge k+MW. Fixed, with no early exit for M=0.
- Throughput: busy is 0 during the pushout cycle. A pushin in that cycle is accepted, giving back-to-back jobs every MW+1 cycles.
- pushin while busy=1: the operands are dropped, err<=1, and the in-flight job is unaffected.
- Outputs P_out, M_out and ovf change only on pushout edges (or reset).
- Reset mid-RUN: the job is abandoned, all outputs return to reset values, and no pushout is produced.
- MW=1 is legal (single RUN edge). cnt width CW holds MW-1.

Decomposition:
- Shared package div_pkg holds constants QW_DEF=72 and MW_DEF=10, the state enum {IDLE,RUN}, and the derived-width function for PW. The divide stages use the same constants.
- No sub-module. The add/shift datapath is small enough to keep inline.

Test Plan:
- Q=7, M=3, R=1, pushin at edge 0 -> busy high for 10 cycles; pushout pulse after edge 10 with P_out=22, M_out=3, ovf=0.
- M=0, Q=0xFFFF, R=5 -> P_out=5 after the full 10-cycle latency, ovf=0.
- Q=2^72-1, M=1023, R=2^72-1 -> P_out=(2^72-1)*1024, ovf=1.
- Job with Q=100, M=9, R=4; second pushin at cycle 3 -> second job dropped, err=1 (stays 1), P_out=904.
- pushin in the pushout cycle with Q=2, M=5, R=0 -> accepted; next pushout 11 cycles after the first with P_out=10.
- Assert rst at cycle 4 of a run -> pushout, P_out and err are 0, busy=0, and no later pushout occurs.
